// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit UART transmit and receive paths:
// frame state encoding, default data width and parity helpers.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_SYNC   = 3'd1,
    UART_TX_START  = 3'd2,
    UART_TX_DATA   = 3'd3,
    UART_TX_PARITY = 3'd4,
    UART_TX_STOP   = 3'd5
  } uart_tx_state_e;

  // Zero-padded upper bits do not disturb the XOR, so narrow frames reuse this.
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      mode);
    return (^data) ^ (mode == PARITY_MODE_ODD);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serial transmitter: valid/ready byte intake, LSB-first start/data/
// parity/stop framing paced by an external one-cycle baud_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_tx_state_e              state_r;
  logic [DATA_BITS-1:0]        shift_r;
  logic [DATA_BITS-1:0]        data_r;
  logic [CNT_W-1:0]            bit_cnt_r;
  logic                        stop_cnt_r;
  logic                        tx_r;
  logic [UART_DATA_BITS-1:0]   data_ext_s;
  logic                        parity_s;

  // Widen the latched byte so the shared parity helper sees a fixed width.
  always_comb begin
    data_ext_s                = '0;
    data_ext_s[DATA_BITS-1:0] = data_r;
    parity_s                  = calc_parity(data_ext_s, PAR_MODE);
  end

  // Frame sequencer: each bit changes only on a baud_tick after SYNC alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= UART_TX_IDLE;
      shift_r    <= '0;
      data_r     <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        UART_TX_IDLE: begin
          tx_r <= 1'b1;
          if (tx_valid) begin
            shift_r    <= tx_data;
            data_r     <= tx_data;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            state_r    <= UART_TX_SYNC;
          end
        end
        UART_TX_SYNC: begin
          if (baud_tick) begin
            tx_r    <= 1'b0;
            state_r <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (baud_tick) begin
            tx_r      <= shift_r[0];
            shift_r   <= shift_r >> 1;
            bit_cnt_r <= '0;
            state_r   <= UART_TX_DATA;
          end
        end
        UART_TX_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_r == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx_r    <= parity_s;
                state_r <= UART_TX_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= UART_TX_STOP;
              end
            end else begin
              tx_r      <= shift_r[0];
              shift_r   <= shift_r >> 1;
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        UART_TX_PARITY: begin
          if (baud_tick) begin
            tx_r    <= 1'b1;
            state_r <= UART_TX_STOP;
          end
        end
        UART_TX_STOP: begin
          tx_r <= 1'b1;
          if (baud_tick) begin
            if (stop_cnt_r == LAST_STOP) begin
              stop_cnt_r <= 1'b0;
              state_r    <= UART_TX_IDLE;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= UART_TX_IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_r;
  assign tx_ready = (state_r == UART_TX_IDLE);
  assign busy     = (state_r != UART_TX_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three framing variants, expected line bits
// queued at stimulus time and compared cycle by cycle on the serial output.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic [7:0] tx_data [3];
  logic tx_valid [3];
  logic tx_w [3];
  logic rdy_w [3];
  logic busy_w [3];

  int tick_div = 4;
  int tick_cnt = 0;
  int checks = 0;
  int errors = 0;
  logic exp_q [$];

  always #5 clk = ~clk;

  // Baud enable source, updated away from the active edge.
  always @(negedge clk) begin
    tick_cnt  = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
    baud_tick = (tick_cnt == 0);
  end

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[2]),
    .tx_valid(tx_valid[2]), .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // idx 0: 8N1, idx 1: 8E1, idx 2: 8O2
  task automatic push_frame(input int idx, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (idx == 1) exp_q.push_back(^d);
    if (idx == 2) exp_q.push_back(~(^d));
    exp_q.push_back(1'b1);
    if (idx == 2) exp_q.push_back(1'b1);
  endtask

  task automatic start_send(input int idx, input logic [7:0] d, input string tag);
    @(negedge clk);
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    push_frame(idx, d);
    @(negedge clk);
    tx_valid[idx] = 1'b0;
    check({tag, " accept_ready_low"}, 32'(rdy_w[idx]), 32'd0);
    check({tag, " accept_busy"}, 32'(busy_w[idx]), 32'd1);
  endtask

  task automatic check_frame(input int idx, input int nbits, input string tag);
    int n;
    logic e;
    n = 0;
    while (tx_w[idx] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " start_timeout"}, 32'(n < 100), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 1'bx;
      for (int c = 0; c < tick_div; c++) begin
        check($sformatf("%s bit%0d cyc%0d", tag, b, c), 32'(tx_w[idx]), 32'(e));
        if (b == nbits - 1 && c == tick_div - 1)
          check({tag, " ready_low_last_stop"}, 32'(rdy_w[idx]), 32'd0);
        @(negedge clk);
      end
    end
    check({tag, " ready_after_stop"}, 32'(rdy_w[idx]), 32'd1);
    check({tag, " busy_after_stop"}, 32'(busy_w[idx]), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    int n;
    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end

    // Reset, then idle with ticks present
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("idle tx%0d", i), 32'(tx_w[i]), 32'd1);
        check($sformatf("idle ready%0d", i), 32'(rdy_w[i]), 32'd1);
        check($sformatf("idle busy%0d", i), 32'(busy_w[i]), 32'd0);
      end
    end

    // 8N1 0xA5, tick every 4 cycles
    start_send(0, 8'hA5, "8n1_a5");
    check_frame(0, 10, "8n1_a5");

    // Even parity, then odd parity with two stop bits
    start_send(1, 8'hA5, "8e1_a5");
    check_frame(1, 11, "8e1_a5");
    start_send(2, 8'hA5, "8o2_a5");
    check_frame(2, 12, "8o2_a5");

    // Back-to-back with tx_valid held and data changed mid-frame
    @(negedge clk);
    tx_data[0]  = 8'h00;
    tx_valid[0] = 1'b1;
    push_frame(0, 8'h00);
    @(negedge clk);
    check("b2b accept1", 32'(rdy_w[0]), 32'd0);
    tx_data[0] = 8'hFF;
    push_frame(0, 8'hFF);
    check_frame(0, 10, "b2b_f1");
    @(negedge clk);
    check("b2b accept2_immediate", 32'(rdy_w[0]), 32'd0);
    tx_valid[0] = 1'b0;
    check_frame(0, 10, "b2b_f2");

    // Reset during data bit 3
    v = 8'h37;
    start_send(0, v, "rst_37");
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst start_timeout", 32'(n < 100), 32'd1);
    repeat (18) @(negedge clk);
    check("rst pre_bit3", 32'(tx_w[0]), 32'(v[3]));
    #1 rst_n = 1'b0;
    #1;
    check("rst tx_high", 32'(tx_w[0]), 32'd1);
    check("rst ready", 32'(rdy_w[0]), 32'd1);
    check("rst busy", 32'(busy_w[0]), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst idle_after_release", 32'(rdy_w[0]), 32'd1);
    start_send(0, 8'h3C, "post_rst_3c");
    check_frame(0, 10, "post_rst_3c");

    // Tick every cycle
    @(negedge clk);
    tick_div = 1;
    start_send(0, 8'h81, "fast_81");
    check_frame(0, 10, "fast_81");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
